fxp_mul_lanes: RTL and testbench
================================

Name: fxp_mul_lanes

Overview:
- Multi-lane, parametrised Q-format signed multiplier; successor to the single-lane truncating Q1.7 multiplier.
- Adds per-transaction rounding mode, per-lane saturation flags, configurable width and fractional bits, and valid/ready backpressure.
- Sits between the ULG coordinator and the lane datapaths. Lets (A*B)*C chains run several lanes per beat under downstream stall.

Parameters:
- LANES, 4, number of parallel lanes sharing one handshake.
- DATA_W, 8, signed operand and result width per lane.
- FRAC_BITS, 7, right shift applied to the 2*DATA_W product. Legal range 1..2*DATA_W-2.
- CNT_W, 16, width of the saturation event counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  input beat accepted when i_valid && i_ready.
- i_data_a  in  LANES*DATA_W  packed signed operand A; lane k at [k*DATA_W +: DATA_W].
- i_data_b  in  LANES*DATA_W  packed signed operand B, same packing.
- i_rnd_mode  in  2  rounding mode, sampled with the beat.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts when o_valid && o_ready.
- o_data  out  LANES*DATA_W  packed signed results.
- o_sat  out  LANES  per-lane flag: result was clamped.
- i_clr_stat  in  1  synchronous clear of the saturation counter (optional feature).
- o_sat_cnt  out  CNT_W  saturation event count (optional feature).

Behaviour:
- clk is the only clock. rst_n is asynchronous, active-low.
- Reset values: o_valid=0, o_data=0, o_sat=0, o_sat_cnt=0. All stage valids 0; all stage data registers 0.
- Pipeline: 3 register stages, latency 3 cycles from accept to o_valid with o_ready held high. Throughput 1 beat/cycle.
  - S1: per-lane signed product, 2*DATA_W bits; rnd_mode carried alongside.
  - S2: rounding bias added in 2*DATA_W+1 bits, so the bias addition never overflows; arithmetic shift right by FRAC_BITS.
  - S3: saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sets o_sat[k].
- Rounding modes:
  - 0 TRUNC: floor, plain arithmetic shift.
  - 1 HALF_UP: add 2^(FRAC_BITS-1), then shift.
  - 2 HALF_EVEN: add 2^(FRAC_BITS-1)-1 plus bit FRAC_BITS of the product, then shift.
  - 3 reserved: behaves as TRUNC.
- Stall control:
  - advance = !o_valid || o_ready. All stages move together only on advance.
  - i_ready = advance.
  - Bubbles are not collapsed during a stall.
- On advance with S2 invalid: o_valid goes 0, o_data and o_sat go 0.
- While stalled (o_valid && !o_ready): o_data, o_sat and o_valid hold stable. No beat is lost or duplicated.
- i_valid without i_ready: the beat is not captured; the upstream source holds it.
- Reset mid-operation: in-flight beats are discarded, outputs return to reset values, i_ready=1 on the first cycle after deassertion.
- Lanes are independent arithmetically. A single rnd_mode applies to all lanes of a beat.

Optional Feature:
- Macro: FXP_MUL_SAT_CNT_EN.
- Defined:
  - o_sat_cnt increments by popcount(o_sat) on each output handshake (o_valid && o_ready).
  - It saturates at 2^CNT_W-1 and does not wrap.
  - i_clr_stat clears it to 0; clear takes priority over a same-cycle increment.
- Undefined: i_clr_stat is ignored and o_sat_cnt is tied to 0. No counter logic is built.

Decomposition:
- Package fxp_pkg:
  - rounding-mode constants RND_TRUNC=0, RND_HALF_UP=1, RND_HALF_EVEN=2.
  - saturation bound constants derived from DATA_W.
  - popcount function.
- Sub-module fxp_round_sat: combinational per-lane bias/shift/clamp. Parameters DATA_W and FRAC_BITS; inputs product and mode; outputs result and sat. Instantiated LANES times, split across the S2/S3 registers.

Test Plan:
- Default params, lane0 a=-128, b=-128, TRUNC -> o_data lane0=127, o_sat[0]=1, 3 cycles after accept. Lane1 a=64, b=64 -> 32, o_sat[1]=0.
- Lane0 a=1, b=64 (0.5): modes 0/1/2 -> 0/1/0. a=3, b=64 (1.5) -> 1/2/2. a=-1, b=64 (-0.5) -> -1/0/0. Mode 3 matches mode 0.
- Back-to-back 8 beats, o_ready=1 -> 8 consecutive output beats in order, one per cycle, after 3-cycle latency.
- Hold o_ready=0 while feeding beats -> i_ready drops once o_valid=1. Outputs stay stable. On release, all beats drain in order with no loss or duplication.
- Assert rst_n=0 with 2 beats in flight and o_ready=0 -> o_valid=0, o_data=0, o_sat=0 immediately. i_ready=1 after release. No stale beat appears.
- With FXP_MUL_SAT_CNT_EN, send 3 beats each saturating 2 lanes -> o_sat_cnt=6. Assert i_clr_stat together with a saturating handshake -> 0. With CNT_W=2, 5 saturations -> 3.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the lane-parallel Q-format multiplier.
package fxp_pkg;

    localparam logic [1:0] RND_TRUNC     = 2'd0;
    localparam logic [1:0] RND_HALF_UP   = 2'd1;
    localparam logic [1:0] RND_HALF_EVEN = 2'd2;

    // Signed saturation bounds for a result of width w.
    function automatic longint sat_hi(input int unsigned w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int unsigned w);
        return -(longint'(1) << (w - 1));
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fxp_mul_lanes_if.sv
// Beat-level valid/ready bus for fxp_mul_lanes: operands in, results and statistics out.
interface fxp_mul_lanes_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic                      i_valid;
    logic                      i_ready;
    logic [LANES*DATA_W-1:0]   i_data_a;
    logic [LANES*DATA_W-1:0]   i_data_b;
    logic [1:0]                i_rnd_mode;
    logic                      o_valid;
    logic                      o_ready;
    logic [LANES*DATA_W-1:0]   o_data;
    logic [LANES-1:0]          o_sat;
    logic                      i_clr_stat;
    logic [CNT_W-1:0]          o_sat_cnt;

    modport master (
        output i_valid, i_data_a, i_data_b, i_rnd_mode, o_ready, i_clr_stat,
        input  i_ready, o_valid, o_data, o_sat, o_sat_cnt
    );

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_rnd_mode, o_ready, i_clr_stat,
        output i_ready, o_valid, o_data, o_sat, o_sat_cnt
    );

endinterface

// File: rtl/fxp_round_sat.sv
// Per-lane rounding (bias + arithmetic shift) and clamp; the two halves sit on either
// side of the S2 register, so the shifted value leaves and re-enters this module.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAC_BITS = 7
) (
    input  logic signed [2*DATA_W-1:0] prod_i,
    input  logic [1:0]                 mode_i,
    output logic signed [2*DATA_W:0]   shift_o,
    input  logic signed [2*DATA_W:0]   shift_i,
    output logic signed [DATA_W-1:0]   result_o,
    output logic                       sat_o
);
    localparam int unsigned EW = 2 * DATA_W + 1;
    localparam logic signed [EW-1:0] SatHi = EW'(sat_hi(DATA_W));
    localparam logic signed [EW-1:0] SatLo = EW'(sat_lo(DATA_W));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] sum;

    // One guard bit above the product keeps the bias addition from overflowing.
    always_comb begin
        ext  = {prod_i[2*DATA_W-1], prod_i};
        bias = '0;
        case (mode_i)
            RND_HALF_UP:   bias = EW'(1) << (FRAC_BITS - 1);
            RND_HALF_EVEN: bias = (EW'(1) << (FRAC_BITS - 1)) - EW'(1) + EW'(prod_i[FRAC_BITS]);
            default:       bias = '0;
        endcase
        sum     = ext + bias;
        shift_o = sum >>> FRAC_BITS;
    end

    always_comb begin
        result_o = shift_i[DATA_W-1:0];
        sat_o    = 1'b0;
        if (shift_i > SatHi) begin
            result_o = SatHi[DATA_W-1:0];
            sat_o    = 1'b1;
        end else if (shift_i < SatLo) begin
            result_o = SatLo[DATA_W-1:0];
            sat_o    = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_mul_lanes.sv
// Multi-lane signed Q-format multiplier, 3-stage pipeline with valid/ready backpressure.
// Optional saturation event counter built only when FXP_MUL_SAT_CNT_EN is defined.
module fxp_mul_lanes
    import fxp_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAC_BITS = 7,
    parameter int unsigned CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fxp_mul_lanes_if.slave bus
);
    localparam int unsigned PW = 2 * DATA_W;

    logic                    adv;
    logic                    s1_valid_q;
    logic [1:0]              s1_mode_q;
    logic signed [PW-1:0]    s1_prod_q [LANES];
    logic                    s2_valid_q;
    logic signed [PW:0]      s2_shift_q [LANES];
    logic                    o_valid_q;
    logic [LANES*DATA_W-1:0] o_data_q;
    logic [LANES-1:0]        o_sat_q;

    logic signed [PW-1:0]     prod_d [LANES];
    logic signed [PW:0]       shift_d [LANES];
    logic signed [DATA_W-1:0] res_d [LANES];
    logic [LANES-1:0]         sat_d;

    // Every stage moves in lockstep; bubbles are kept while stalled.
    assign adv         = !o_valid_q || bus.o_ready;
    assign bus.i_ready = adv;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_sat   = o_sat_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign prod_d[k] = PW'($signed(bus.i_data_a[k*DATA_W +: DATA_W]))
                         * PW'($signed(bus.i_data_b[k*DATA_W +: DATA_W]));

        fxp_round_sat #(
            .DATA_W    (DATA_W),
            .FRAC_BITS (FRAC_BITS)
        ) u_round_sat (
            .prod_i   (s1_prod_q[k]),
            .mode_i   (s1_mode_q),
            .shift_o  (shift_d[k]),
            .shift_i  (s2_shift_q[k]),
            .result_o (res_d[k]),
            .sat_o    (sat_d[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s2_valid_q <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_sat_q    <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_prod_q[k]  <= '0;
                s2_shift_q[k] <= '0;
            end
        end else if (adv) begin
            s1_valid_q <= bus.i_valid;
            s1_mode_q  <= bus.i_valid ? bus.i_rnd_mode : 2'b00;
            s2_valid_q <= s1_valid_q;
            o_valid_q  <= s2_valid_q;
            o_sat_q    <= s2_valid_q ? sat_d : '0;
            for (int k = 0; k < LANES; k++) begin
                s1_prod_q[k]                  <= bus.i_valid ? prod_d[k] : '0;
                s2_shift_q[k]                 <= s1_valid_q ? shift_d[k] : '0;
                o_data_q[k*DATA_W +: DATA_W]  <= s2_valid_q ? res_d[k] : '0;
            end
        end
    end

`ifdef FXP_MUL_SAT_CNT_EN
    localparam logic [32:0] CntMax = (33'd1 << CNT_W) - 33'd1;

    logic [CNT_W-1:0] sat_cnt_q;
    logic [CNT_W-1:0] sat_cnt_d;
    logic [32:0]      cnt_sum;

    // Clear wins over a same-cycle increment; the count sticks at its maximum.
    always_comb begin
        cnt_sum   = 33'(sat_cnt_q) + 33'(popcount(64'(o_sat_q)));
        sat_cnt_d = sat_cnt_q;
        if (bus.i_clr_stat) begin
            sat_cnt_d = '0;
        end else if (o_valid_q && bus.o_ready) begin
            sat_cnt_d = (cnt_sum > CntMax) ? CntMax[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign bus.o_sat_cnt = sat_cnt_q;
`else
    logic unused_clr_stat;
    assign unused_clr_stat = bus.i_clr_stat;
    assign bus.o_sat_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fxp_mul_lanes.sv
// Directed self-checking bench for fxp_mul_lanes (default parameters).
module tb_fxp_mul_lanes;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [7:0] HALF = 8'h40;
    localparam logic [7:0] MINV = 8'h80;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fxp_mul_lanes_if #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fxp_mul_lanes #(
        .LANES     (LANES),
        .DATA_W    (DATA_W),
        .FRAC_BITS (7),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef FXP_MUL_SAT_CNT_EN
    fxp_mul_lanes_if #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(2)) bus2 ();

    fxp_mul_lanes #(
        .LANES     (LANES),
        .DATA_W    (DATA_W),
        .FRAC_BITS (7),
        .CNT_W     (2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );
`endif

    function automatic logic [7:0] lane_of(input logic [LANES*DATA_W-1:0] d, input int k);
        return d[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_beat(input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1,
                            input logic [1:0] mode);
        bus.i_data_a        = '0;
        bus.i_data_b        = '0;
        bus.i_data_a[7:0]   = a0;
        bus.i_data_b[7:0]   = b0;
        bus.i_data_a[15:8]  = a1;
        bus.i_data_b[15:8]  = b1;
        bus.i_rnd_mode      = mode;
    endtask

    // Sends one beat, waits (bounded) for its result, then lets the output handshake complete.
    task automatic run_single(input logic [7:0] a0, input logic [7:0] b0,
                              input logic [7:0] a1, input logic [7:0] b1,
                              input logic [1:0] mode,
                              output logic [LANES*DATA_W-1:0] data,
                              output logic [LANES-1:0] sat, output bit ok);
        int n;
        bus.o_ready = 1'b1;
        set_beat(a0, b0, a1, b1, mode);
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        n = 1;
        while (!bus.o_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        ok   = bus.o_valid;
        data = bus.o_data;
        sat  = bus.o_sat;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++; $display("FAIL reset_o_valid got=%0b want=0", bus.o_valid);
        end
        checks++;
        if (bus.o_data !== '0) begin
            failures++; $display("FAIL reset_o_data got=%h want=0", bus.o_data);
        end
        checks++;
        if (bus.o_sat !== '0) begin
            failures++; $display("FAIL reset_o_sat got=%b want=0", bus.o_sat);
        end
        checks++;
        if (bus.o_sat_cnt !== '0) begin
            failures++; $display("FAIL reset_o_sat_cnt got=%0d want=0", bus.o_sat_cnt);
        end
        checks++;
        if (bus.i_ready !== 1'b1) begin
            failures++; $display("FAIL reset_i_ready got=%0b want=1", bus.i_ready);
        end
    endtask

    task automatic test_saturation();
        bus.o_ready = 1'b1;
        set_beat(MINV, MINV, HALF, HALF, 2'd0);
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++; $display("FAIL lat_edge1 o_valid got=%0b want=0", bus.o_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++; $display("FAIL lat_edge2 o_valid got=%0b want=0", bus.o_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b1) begin
            failures++; $display("FAIL lat_edge3 o_valid got=%0b want=1", bus.o_valid);
        end
        checks++;
        if (lane_of(bus.o_data, 0) !== 8'd127 || lane_of(bus.o_data, 1) !== 8'd32) begin
            failures++;
            $display("FAIL sat_data lane0=%0d lane1=%0d want 127 32",
                     $signed(lane_of(bus.o_data, 0)), $signed(lane_of(bus.o_data, 1)));
        end
        checks++;
        if (bus.o_sat !== 4'b0001) begin
            failures++; $display("FAIL sat_flags got=%b want=0001", bus.o_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rounding();
        logic [7:0] a_t [12];
        logic [1:0] m_t [12];
        logic [7:0] e0_t [12];
        logic [7:0] e1_t [12];
        logic [LANES*DATA_W-1:0] d;
        logic [LANES-1:0] s;
        bit ok;
        // lane0: a*0.5 for a in {1,3,-1}; lane1 fixed 5*0.5 = 2.5
        a_t  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd3, 8'd3, 8'd3, 8'd3,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        m_t  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                 2'd0, 2'd1, 2'd2, 2'd3};
        e0_t = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd1,
                 8'hFF, 8'd0, 8'd0, 8'hFF};
        e1_t = '{8'd2, 8'd3, 8'd2, 8'd2, 8'd2, 8'd3, 8'd2, 8'd2,
                 8'd2, 8'd3, 8'd2, 8'd2};
        for (int i = 0; i < 12; i++) begin
            run_single(a_t[i], HALF, 8'd5, HALF, m_t[i], d, s, ok);
            checks++;
            if (!ok || lane_of(d, 0) !== e0_t[i] || lane_of(d, 1) !== e1_t[i] || s !== '0) begin
                failures++;
                $display("FAIL round_%0d mode=%0d ok=%0b got=%0d,%0d sat=%b want=%0d,%0d sat=0",
                         i, m_t[i], ok, $signed(lane_of(d, 0)), $signed(lane_of(d, 1)), s,
                         $signed(e0_t[i]), $signed(e1_t[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int first_t = -1;
        int last_t = -1;
        bus.o_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (t < 8) begin
                set_beat(8'(2 * (t + 1)), HALF, 8'(t), MINV, 2'd0);
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.o_valid) begin
                if (first_t < 0) first_t = t;
                last_t = t;
                checks++;
                if (lane_of(bus.o_data, 0) !== 8'(got + 1) || lane_of(bus.o_data, 1) !== 8'(-got)) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got=%0d,%0d want=%0d,%0d", got,
                             $signed(lane_of(bus.o_data, 0)), $signed(lane_of(bus.o_data, 1)),
                             got + 1, -got);
                end
                got++;
            end
        end
        checks++;
        if (got != 8 || first_t != 2 || last_t != 9) begin
            failures++;
            $display("FAIL b2b_timing count=%0d first=%0d last=%0d want 8 2 9", got, first_t, last_t);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got = 0;
        bit acc;
        bit out;
        logic [LANES*DATA_W-1:0] snap_d;
        logic [LANES-1:0] snap_s;
        for (int t = 0; t < 40 && got < 5; t++) begin
            bus.o_ready = (t >= 8);
            bus.i_valid = (sent < 5);
            set_beat(8'(2 * (sent + 1)), HALF, 8'd0, 8'd0, 2'd0);
            #1;
            acc = bus.i_valid && bus.i_ready;
            out = bus.o_valid && bus.o_ready;
            if (t == 4) begin
                snap_d = bus.o_data;
                snap_s = bus.o_sat;
            end
            if (t == 7) begin
                checks++;
                if (bus.o_valid !== 1'b1 || bus.i_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_ctrl o_valid=%0b i_ready=%0b want 1 0", bus.o_valid, bus.i_ready);
                end
                checks++;
                if (bus.o_data !== snap_d || bus.o_sat !== snap_s) begin
                    failures++;
                    $display("FAIL stall_hold got=%h/%b want=%h/%b", bus.o_data, bus.o_sat, snap_d, snap_s);
                end
            end
            if (t == 8) begin
                checks++;
                if (sent != 3) begin
                    failures++; $display("FAIL stall_accepted got=%0d want=3", sent);
                end
            end
            if (out) begin
                checks++;
                if (lane_of(bus.o_data, 0) !== 8'(got + 1)) begin
                    failures++;
                    $display("FAIL stall_order beat%0d got=%0d want=%0d", got,
                             $signed(lane_of(bus.o_data, 0)), got + 1);
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (sent != 5 || got != 5) begin
            failures++; $display("FAIL stall_drain sent=%0d got=%0d want 5 5", sent, got);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++; $display("FAIL stall_no_dup o_valid=%0b want=0", bus.o_valid);
        end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        bus.o_ready = 1'b0;
        set_beat(MINV, MINV, 8'd0, 8'd0, 2'd0);
        bus.i_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_sat !== 4'b0001) begin
            failures++;
            $display("FAIL rst_pre o_valid=%0b o_sat=%b want 1 0001", bus.o_valid, bus.o_sat);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_data !== '0 || bus.o_sat !== '0) begin
            failures++;
            $display("FAIL rst_async o_valid=%0b o_data=%h o_sat=%b want 0 0 0",
                     bus.o_valid, bus.o_data, bus.o_sat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.i_ready !== 1'b1) begin
            failures++; $display("FAIL rst_i_ready got=%0b want=1", bus.i_ready);
        end
        bus.o_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.o_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL rst_stale beats=%0d want=0", seen);
        end
    endtask

    task automatic test_sat_cnt();
        logic [LANES*DATA_W-1:0] d;
        logic [LANES-1:0] s;
        bit ok;
`ifdef FXP_MUL_SAT_CNT_EN
        int n;
        repeat (3) run_single(MINV, MINV, MINV, MINV, 2'd0, d, s, ok);
        checks++;
        if (bus.o_sat_cnt !== 16'd6) begin
            failures++; $display("FAIL cnt_six got=%0d want=6", bus.o_sat_cnt);
        end
        set_beat(MINV, MINV, MINV, MINV, 2'd0);
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        bus.i_clr_stat = 1'b1;
        @(posedge clk); #1;
        bus.i_clr_stat = 1'b0;
        checks++;
        if (bus.o_sat_cnt !== '0) begin
            failures++; $display("FAIL cnt_clear got=%0d want=0", bus.o_sat_cnt);
        end
        // Narrow counter: 2+2+1 saturations must stick at 3.
        bus2.o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus2.i_data_a = {16'd0, (i == 2) ? 8'd1 : MINV, MINV};
            bus2.i_data_b = {16'd0, (i == 2) ? 8'd1 : MINV, MINV};
            bus2.i_valid  = 1'b1;
            @(posedge clk); #1;
        end
        bus2.i_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus2.o_sat_cnt !== 2'd3) begin
            failures++; $display("FAIL cnt_narrow got=%0d want=3", bus2.o_sat_cnt);
        end
`else
        bus.i_clr_stat = 1'b0;
        run_single(MINV, MINV, MINV, MINV, 2'd0, d, s, ok);
        checks++;
        if (!ok || s !== 4'b0011 || bus.o_sat_cnt !== '0) begin
            failures++;
            $display("FAIL cnt_disabled ok=%0b sat=%b cnt=%0d want 1 0011 0", ok, s, bus.o_sat_cnt);
        end
`endif
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.o_ready    = 1'b1;
        bus.i_clr_stat = 1'b0;
        bus.i_data_a   = '0;
        bus.i_data_b   = '0;
        bus.i_rnd_mode = '0;
`ifdef FXP_MUL_SAT_CNT_EN
        bus2.i_valid    = 1'b0;
        bus2.o_ready    = 1'b1;
        bus2.i_clr_stat = 1'b0;
        bus2.i_data_a   = '0;
        bus2.i_data_b   = '0;
        bus2.i_rnd_mode = '0;
`endif
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_sat_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
